apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//  Shares one APB master port among NUM_REQ local requesters (DMA, CPU bridge, debug, ...).
//  Round-robin arbitration, captures the winner's command, then sequences the APB SETUP/ACCESS
//  phases and returns PRDATA/PSLVERR to the winner. It is the sole driver of the APB master signals.
// PARAMETERS
//  NUM_REQ         4    number of requesters (2..8)
//  ADDR_W          32   paddr / req_addr width
//  DATA_W          32   pwdata/prdata width; strobe width = DATA_W/8
//  TIMEOUT_CYCLES  256  ACCESS-phase wait limit (APB_ARB_TIMEOUT_EN only); >=2
// PORTS
//  pclk        in   1               APB clock; all logic is on its rising edge
//  presetn     in   1               asynchronous active-low reset
//  req_valid   in   NUM_REQ         per-requester command valid
//  req_ready   out  NUM_REQ         one-hot, 1-cycle pulse: command accepted
//  req_write   in   NUM_REQ         1 = write
//  req_addr    in   NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata   in   NUM_REQ*DATA_W  packed write data
//  req_strb    in   NUM_REQ*DATA_W/8 packed byte strobes
//  req_prot    in   NUM_REQ*3       packed pprot
//  rsp_valid   out  NUM_REQ         one-hot, 1-cycle completion pulse
//  rsp_rdata   out  DATA_W          read data, valid with rsp_valid (0 for writes)
//  rsp_slverr  out  1               error flag, valid with rsp_valid
//  paddr/pprot/psel/penable/pwrite/pwdata/pstrb  out  APB master outputs (widths as above)
//  pready/prdata/pslverr                          in   APB completer responses
// BEHAVIOUR
//  - Reset (presetn low, async): all outputs 0; FSM=IDLE; rr pointer = NUM_REQ-1 (requester 0 wins first).
//  - FSM: IDLE -> SETUP -> ACCESS -> IDLE. All outputs registered.
//  - IDLE: if any req_valid, winner = first valid index after rr pointer (wrap modulo NUM_REQ);
//    same cycle req_ready[winner]=1 (combinational from registered state+req_valid), command
//    captured at edge, rr pointer := winner, go SETUP. No valid -> stay IDLE, outputs hold 0.
//  - SETUP (1 cycle): psel=1, penable=0, paddr/pwrite/pwdata/pstrb/pprot = captured command.
//  - ACCESS: psel=1, penable=1, signals stable; stay while pready=0.
//    pready=1 -> next cycle: psel=penable=0, rsp_valid[winner]=1, rsp_rdata=prdata (read) else 0,
//    rsp_slverr=pslverr; FSM=IDLE.
//  - Latency: accept at T -> psel at T+1 -> penable at T+2 -> (pready at T+2) rsp_valid at T+3.
//    Arbitration for the next command runs in the same cycle as rsp_valid; min 3 cycles/transfer.
//  - Requester must hold req_* stable while req_valid=1 and req_ready=0; dropping valid before
//    ready withdraws the request without side effect. req_ready never asserts outside IDLE.
//  - pwdata/pstrb driven 0 on reads; address/control hold last value only while psel=1, else 0.
//  - Simultaneous request from all: fixed RR rotation 0,1,2,3,0,... no requester starves.
//  - Reset mid-transfer: transfer abandoned, no rsp_valid issued, psel drops asynchronously.
// CONFIGURATION
//  APB_ARB_TIMEOUT_EN defined: counter cleared on SETUP, increments each ACCESS cycle with pready=0;
//    when it reaches TIMEOUT_CYCLES, psel/penable drop next cycle, rsp_valid[winner]=1,
//    rsp_slverr=1, rsp_rdata=0, FSM=IDLE. A pready seen in the same cycle wins over timeout.
//  Not defined: no counter; ACCESS waits on pready indefinitely.
// TESTING
//  1. Single read, req 2, addr 0x1000, pready same cycle, prdata 0xCAFE_F00D -> psel T+1, penable
//     T+2, rsp_valid[2] T+3, rsp_rdata 0xCAFEF00D, slverr 0.
//  2. All 4 requesters valid continuously, 8 writes -> grant order 0,1,2,3,0,1,2,3; each pwdata
//     equals its requester's req_wdata; transfers every 3 cycles.
//  3. Write with 5 wait states (pready low 5 ACCESS cycles), pslverr=1 -> signals stable through
//     wait, rsp_valid 1 cycle after pready, rsp_slverr=1, rsp_rdata=0.
//  4. presetn low during ACCESS -> psel/penable/rsp_valid 0 immediately; after release req 0 is
//     granted first and completes normally.
//  5. APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready held 0 -> abort after 16 ACCESS cycles,
//     rsp_slverr=1, rsp_rdata=0; next queued request proceeds.
//  6. req_valid[1] pulsed while another transfer busy, dropped before IDLE -> no grant to 1,
//     no APB cycle for it.

Source files
------------

// File: rtl/apb_master_arbiter_if.sv
// ============================================================================
// Module   : apb_master_arbiter_if
// Brief    : Requester command/response and APB master signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_master_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Requester side
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ*STRB_W-1:0] req_strb;
    logic [NUM_REQ*3-1:0]      req_prot;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_slverr;

    // APB master side
    logic [ADDR_W-1:0]         paddr;
    logic [2:0]                pprot;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [DATA_W-1:0]         pwdata;
    logic [STRB_W-1:0]         pstrb;
    logic                      pready;
    logic [DATA_W-1:0]         prdata;
    logic                      pslverr;

    // The arbiter itself
    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  pready, prdata, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb
    );

    // Requesters plus APB completer
    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output pready, prdata, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb
    );
endinterface

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
// Module   : apb_master_arbiter
// Brief    : Round-robin arbiter sharing one APB master port among NUM_REQ
//            requesters. Optional ACCESS timeout via APB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_master_arbiter_if.master bus
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_IDX_W  = $clog2(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || (DATA_W % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
            $error("apb_master_arbiter: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_winner;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [ADDR_W-1:0]    r_paddr;
    logic [2:0]           r_pprot;
    logic [DATA_W-1:0]    r_pwdata;
    logic [c_STRB_W-1:0]  r_pstrb;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_rsp_slverr;

    logic                 w_any;
    logic [c_IDX_W-1:0]   w_win;
    logic [c_IDX_W:0]     w_cand;
    logic [c_IDX_W-1:0]   w_sel;
    logic                 w_tmo_hit;
    logic                 w_done;

    // Scan from the slot after the last winner, wrapping modulo NUM_REQ
    always_comb begin
        w_any  = 1'b0;
        w_win  = r_rr_ptr;
        w_cand = '0;
        w_sel  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
            if (w_cand >= (c_IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (c_IDX_W+1)'(NUM_REQ);
            end
            w_sel = w_cand[c_IDX_W-1:0];
            if (!w_any && bus.req_valid[w_sel]) begin
                w_any = 1'b1;
                w_win = w_sel;
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_TMO_W-1:0] r_tmo_cnt;

    // This wait cycle would bring the count to TIMEOUT_CYCLES
    assign w_tmo_hit = (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    assign w_done = (r_state == ST_ACCESS) && (bus.pready || w_tmo_hit);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= c_IDX_W'(NUM_REQ - 1);
            r_winner     <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pprot      <= '0;
            r_pwdata     <= '0;
            r_pstrb      <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            r_tmo_cnt    <= '0;
`endif
        end else begin
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state   <= ST_SETUP;
                        r_rr_ptr  <= w_win;
                        r_winner  <= w_win;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= bus.req_write[w_win];
                        r_paddr   <= bus.req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                        r_pprot   <= bus.req_prot[int'(w_win)*3 +: 3];
                        r_pwdata  <= bus.req_write[w_win] ?
                                     bus.req_wdata[int'(w_win)*DATA_W +: DATA_W] : '0;
                        r_pstrb   <= bus.req_write[w_win] ?
                                     bus.req_strb[int'(w_win)*c_STRB_W +: c_STRB_W] : '0;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (w_done) begin
                        r_state      <= ST_IDLE;
                        r_psel       <= 1'b0;
                        r_penable    <= 1'b0;
                        r_pwrite     <= 1'b0;
                        r_paddr      <= '0;
                        r_pprot      <= '0;
                        r_pwdata     <= '0;
                        r_pstrb      <= '0;
                        r_rsp_valid  <= NUM_REQ'(1) << r_winner;
                        // A real pready outranks a simultaneous timeout
                        r_rsp_slverr <= bus.pready ? bus.pslverr : 1'b1;
                        r_rsp_rdata  <= (bus.pready && !r_pwrite) ? bus.prdata : '0;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE && w_any) ? (NUM_REQ'(1) << w_win) : '0;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_slverr = r_rsp_slverr;
    assign bus.paddr      = r_paddr;
    assign bus.pprot      = r_pprot;
    assign bus.psel       = r_psel;
    assign bus.penable    = r_penable;
    assign bus.pwrite     = r_pwrite;
    assign bus.pwdata     = r_pwdata;
    assign bus.pstrb      = r_pstrb;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
// Module   : tb_apb_master_arbiter
// Brief    : Directed self-checking bench for apb_master_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 16;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    apb_master_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus.master)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
        bus.req_write[i]           = wr;
        bus.req_addr[i*32 +: 32]   = a;
        bus.req_wdata[i*32 +: 32]  = d;
        bus.req_strb[i*4 +: 4]     = s;
        bus.req_prot[i*3 +: 3]     = p;
    endtask

    task automatic test_reset();
        presetn       = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.req_prot  = '0;
        bus.pready    = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        n_checks++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b000) begin n_errors++; $display("FAIL rst_ctrl: got %b exp 000", {bus.psel, bus.penable, bus.pwrite}); end
        n_checks++; if (bus.paddr !== 32'h0) begin n_errors++; $display("FAIL rst_paddr: got %h exp 0", bus.paddr); end
        n_checks++; if (bus.pwdata !== 32'h0) begin n_errors++; $display("FAIL rst_pwdata: got %h exp 0", bus.pwdata); end
        n_checks++; if (bus.rsp_valid !== 4'b0) begin n_errors++; $display("FAIL rst_rsp_valid: got %b exp 0000", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 4'b0) begin n_errors++; $display("FAIL rst_req_ready: got %b exp 0000", bus.req_ready); end
        tick();
        presetn = 1'b1;
    endtask

    task automatic test_single_read();
        set_req(2, 1'b0, 32'h0000_1000, 32'h1111_1111, 4'hF, 3'b001);
        bus.req_valid = 4'b0100;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_errors++; $display("FAIL rd_ready: got %b exp 0100", bus.req_ready); end
        n_checks++; if (bus.psel !== 1'b0) begin n_errors++; $display("FAIL rd_psel_T: got %b exp 0", bus.psel); end
        tick();
        bus.req_valid = '0;
        bus.pready    = 1'b1;
        bus.prdata    = 32'hCAFE_F00D;
        #1;
        n_checks++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b100) begin n_errors++; $display("FAIL rd_setup_ctrl: got %b exp 100", {bus.psel, bus.penable, bus.pwrite}); end
        n_checks++; if (bus.paddr !== 32'h0000_1000) begin n_errors++; $display("FAIL rd_paddr: got %h exp 00001000", bus.paddr); end
        n_checks++; if ({bus.pwdata, bus.pstrb} !== 36'h0) begin n_errors++; $display("FAIL rd_wdata_strb: got %h/%h exp 0/0", bus.pwdata, bus.pstrb); end
        n_checks++; if (bus.pprot !== 3'b001) begin n_errors++; $display("FAIL rd_pprot: got %b exp 001", bus.pprot); end
        tick();
        n_checks++; if ({bus.psel, bus.penable} !== 2'b11) begin n_errors++; $display("FAIL rd_access: got %b exp 11", {bus.psel, bus.penable}); end
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b0100) begin n_errors++; $display("FAIL rd_rsp_valid: got %b exp 0100", bus.rsp_valid); end
        n_checks++; if (bus.rsp_rdata !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL rd_rdata: got %h exp cafef00d", bus.rsp_rdata); end
        n_checks++; if (bus.rsp_slverr !== 1'b0) begin n_errors++; $display("FAIL rd_slverr: got %b exp 0", bus.rsp_slverr); end
        n_checks++; if ({bus.psel, bus.penable, bus.paddr} !== 34'h0) begin n_errors++; $display("FAIL rd_idle_bus: got %b%b/%h exp 00/0", bus.psel, bus.penable, bus.paddr); end
        tick();
        bus.pready = 1'b0;
        n_checks++; if (bus.rsp_valid !== 4'b0) begin n_errors++; $display("FAIL rd_rsp_pulse: got %b exp 0000", bus.rsp_valid); end
    endtask

    task automatic test_rr_writes();
        logic [3:0]  exp_oh;
        logic [3:0]  prev_oh;
        logic [31:0] exp_d;
        logic [31:0] exp_a;
        presetn = 1'b0;
        tick();
        presetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 1'b1, 32'h4000_0000 + 32'(i * 16), 32'hA5A5_0000 + 32'(i), 4'(4'hF ^ i), 3'(i));
        end
        bus.req_valid = 4'hF;
        bus.pready    = 1'b1;
        for (int n = 0; n < 8; n++) begin
            exp_oh  = 4'b0001 << (n % 4);
            prev_oh = 4'b0001 << ((n + 3) % 4);
            exp_d   = 32'hA5A5_0000 + 32'(n % 4);
            exp_a   = 32'h4000_0000 + 32'((n % 4) * 16);
            #1;
            n_checks++; if (bus.req_ready !== exp_oh) begin n_errors++; $display("FAIL rr_grant%0d: got %b exp %b", n, bus.req_ready, exp_oh); end
            if (n > 0) begin
                n_checks++; if (bus.rsp_valid !== prev_oh) begin n_errors++; $display("FAIL rr_rsp%0d: got %b exp %b", n, bus.rsp_valid, prev_oh); end
            end
            tick();
            n_checks++; if ({bus.psel, bus.penable, bus.pwrite} !== 3'b101) begin n_errors++; $display("FAIL rr_setup%0d: got %b exp 101", n, {bus.psel, bus.penable, bus.pwrite}); end
            n_checks++; if (bus.pwdata !== exp_d) begin n_errors++; $display("FAIL rr_pwdata%0d: got %h exp %h", n, bus.pwdata, exp_d); end
            n_checks++; if (bus.paddr !== exp_a) begin n_errors++; $display("FAIL rr_paddr%0d: got %h exp %h", n, bus.paddr, exp_a); end
            n_checks++; if (bus.pstrb !== 4'(4'hF ^ (n % 4))) begin n_errors++; $display("FAIL rr_pstrb%0d: got %h exp %h", n, bus.pstrb, 4'(4'hF ^ (n % 4))); end
            tick();
            n_checks++; if (bus.penable !== 1'b1) begin n_errors++; $display("FAIL rr_access%0d: got %b exp 1", n, bus.penable); end
            tick();
        end
        bus.req_valid = '0;
        #1;
        n_checks++; if (bus.rsp_valid !== 4'b1000) begin n_errors++; $display("FAIL rr_rsp_last: got %b exp 1000", bus.rsp_valid); end
        n_checks++; if (bus.req_ready !== 4'b0) begin n_errors++; $display("FAIL rr_ready_off: got %b exp 0000", bus.req_ready); end
        tick();
        bus.pready = 1'b0;
    endtask

    task automatic test_wait_states();
        set_req(1, 1'b1, 32'h2000_0040, 32'h1234_5678, 4'b0011, 3'b010);
        bus.req_valid = 4'b0010;
        bus.pready    = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0010) begin n_errors++; $display("FAIL ws_ready: got %b exp 0010", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        #1;
        n_checks++; if ({bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot} !== {1'b1, 32'h1234_5678, 4'b0011, 3'b010}) begin n_errors++; $display("FAIL ws_setup_cmd: got %b/%h/%b/%b exp 1/12345678/0011/010", bus.pwrite, bus.pwdata, bus.pstrb, bus.pprot); end
        tick();
        for (int w = 0; w < 5; w++) begin
            n_checks++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 6'b110000) begin n_errors++; $display("FAIL ws_wait%0d_ctrl: got %b exp 110000", w, {bus.psel, bus.penable, bus.rsp_valid}); end
            n_checks++; if ({bus.paddr, bus.pwdata} !== {32'h2000_0040, 32'h1234_5678}) begin n_errors++; $display("FAIL ws_wait%0d_stable: got %h/%h exp 20000040/12345678", w, bus.paddr, bus.pwdata); end
            tick();
        end
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        bus.prdata  = 32'hDEAD_BEEF;
        #1;
        n_checks++; if ({bus.psel, bus.penable} !== 2'b11) begin n_errors++; $display("FAIL ws_last_access: got %b exp 11", {bus.psel, bus.penable}); end
        tick();
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        n_checks++; if (bus.rsp_valid !== 4'b0010) begin n_errors++; $display("FAIL ws_rsp_valid: got %b exp 0010", bus.rsp_valid); end
        n_checks++; if ({bus.rsp_slverr, bus.rsp_rdata} !== {1'b1, 32'h0}) begin n_errors++; $display("FAIL ws_rsp_err: got %b/%h exp 1/0", bus.rsp_slverr, bus.rsp_rdata); end
        n_checks++; if (bus.psel !== 1'b0) begin n_errors++; $display("FAIL ws_psel_drop: got %b exp 0", bus.psel); end
        tick();
        n_checks++; if (bus.rsp_valid !== 4'b0) begin n_errors++; $display("FAIL ws_rsp_pulse: got %b exp 0000", bus.rsp_valid); end
    endtask

    task automatic test_reset_mid();
        set_req(2, 1'b1, 32'h0000_3000, 32'h0000_0077, 4'hF, 3'b000);
        bus.req_valid = 4'b0100;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0100) begin n_errors++; $display("FAIL rm_ready: got %b exp 0100", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        bus.pready    = 1'b0;
        tick();
        n_checks++; if (bus.penable !== 1'b1) begin n_errors++; $display("FAIL rm_in_access: got %b exp 1", bus.penable); end
        presetn = 1'b0;
        #1;
        n_checks++; if ({bus.psel, bus.penable, bus.rsp_valid} !== 6'b0) begin n_errors++; $display("FAIL rm_async_drop: got %b exp 000000", {bus.psel, bus.penable, bus.rsp_valid}); end
        tick();
        tick();
        presetn = 1'b1;
        set_req(0, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'b000);
        bus.req_valid = 4'b0101;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL rm_first_grant: got %b exp 0001", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 4'b0) begin n_errors++; $display("FAIL rm_no_rsp: got %b exp 0000", bus.rsp_valid); end
        tick();
        bus.req_valid = '0;
        bus.pready    = 1'b1;
        bus.prdata    = 32'h5555_AAAA;
        n_checks++; if ({bus.psel, bus.paddr} !== {1'b1, 32'h0000_5000}) begin n_errors++; $display("FAIL rm_setup: got %b/%h exp 1/00005000", bus.psel, bus.paddr); end
        tick();
        tick();
        n_checks++; if ({bus.rsp_valid, bus.rsp_rdata} !== {4'b0001, 32'h5555_AAAA}) begin n_errors++; $display("FAIL rm_complete: got %b/%h exp 0001/5555aaaa", bus.rsp_valid, bus.rsp_rdata); end
        bus.pready = 1'b0;
        tick();
    endtask

    task automatic test_withdraw();
        set_req(3, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 3'b000);
        set_req(1, 1'b1, 32'h0000_7000, 32'h0BAD_0001, 4'hF, 3'b000);
        bus.req_valid = 4'b1000;
        #1;
        n_checks++; if (bus.req_ready !== 4'b1000) begin n_errors++; $display("FAIL wd_ready3: got %b exp 1000", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0010;
        bus.pready    = 1'b0;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0) begin n_errors++; $display("FAIL wd_busy_setup: got %b exp 0000", bus.req_ready); end
        tick();
        n_checks++; if (bus.req_ready !== 4'b0) begin n_errors++; $display("FAIL wd_busy_access: got %b exp 0000", bus.req_ready); end
        bus.req_valid = '0;
        bus.pready    = 1'b1;
        tick();
        bus.pready = 1'b0;
        n_checks++; if ({bus.rsp_valid, bus.req_ready} !== 8'b1000_0000) begin n_errors++; $display("FAIL wd_rsp3: got %b/%b exp 1000/0000", bus.rsp_valid, bus.req_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if ({bus.psel, bus.req_ready} !== 5'b0) begin n_errors++; $display("FAIL wd_idle%0d: got %b/%b exp 0/0000", c, bus.psel, bus.req_ready); end
        end
    endtask

`ifdef APB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        set_req(0, 1'b0, 32'h0000_8000, 32'h0, 4'h0, 3'b000);
        set_req(1, 1'b0, 32'h0000_9000, 32'h0, 4'h0, 3'b000);
        bus.req_valid = 4'b0011;
        bus.pready    = 1'b0;
        bus.prdata    = 32'hFFFF_FFFF;
        #1;
        n_checks++; if (bus.req_ready !== 4'b0001) begin n_errors++; $display("FAIL to_ready0: got %b exp 0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0010;
        tick();
        for (int a = 0; a < TIMEOUT_CYCLES; a++) begin
            n_checks++; if ({bus.psel, bus.penable, bus.rsp_valid, bus.req_ready} !== 10'b11_0000_0000) begin n_errors++; $display("FAIL to_wait%0d: got %b exp 1100000000", a, {bus.psel, bus.penable, bus.rsp_valid, bus.req_ready}); end
            tick();
        end
        #1;
        n_checks++; if ({bus.rsp_valid, bus.rsp_slverr, bus.rsp_rdata} !== {4'b0001, 1'b1, 32'h0}) begin n_errors++; $display("FAIL to_abort: got %b/%b/%h exp 0001/1/0", bus.rsp_valid, bus.rsp_slverr, bus.rsp_rdata); end
        n_checks++; if ({bus.psel, bus.req_ready} !== 5'b0_0010) begin n_errors++; $display("FAIL to_next_grant: got %b/%b exp 0/0010", bus.psel, bus.req_ready); end
        tick();
        bus.req_valid = '0;
        bus.pready    = 1'b1;
        bus.prdata    = 32'h0BAD_CAFE;
        n_checks++; if ({bus.psel, bus.paddr} !== {1'b1, 32'h0000_9000}) begin n_errors++; $display("FAIL to_setup1: got %b/%h exp 1/00009000", bus.psel, bus.paddr); end
        tick();
        tick();
        n_checks++; if ({bus.rsp_valid, bus.rsp_slverr, bus.rsp_rdata} !== {4'b0010, 1'b0, 32'h0BAD_CAFE}) begin n_errors++; $display("FAIL to_rsp1: got %b/%b/%h exp 0010/0/0badcafe", bus.rsp_valid, bus.rsp_slverr, bus.rsp_rdata); end
        bus.pready = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_rr_writes();
        test_wait_states();
        test_reset_mid();
        test_withdraw();
`ifdef APB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
